// File: rtl/bus_master_8088.sv
// Minimum-mode 8088 bus initiator: turns single host transfer requests into
// T1..T4 bus cycles on the multiplexed pin interface. Wait states are inserted
// while READY is low, and a wait-state counter can abort a stuck cycle.
module bus_master_8088 #(
  parameter int MAX_WAIT = 15,
  parameter int AW       = 20
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_io,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_wdata,
  output logic          rsp_valid,
  output logic [7:0]    rsp_rdata,
  output logic          rsp_err,
  output logic          ALE,
  output logic          RD_n,
  output logic          WR_n,
  output logic          IOM,
  output logic          DEN_n,
  output logic          DTR,
  output logic [AW-9:0] A,
  inout  wire  [7:0]    AD,
  input  logic          READY
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    TW,
    T4
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          cur_write;
  logic [7:0]    cur_wdata;
  logic [7:0]    ad_out;
  logic          ad_oe;
  logic          wait_expired;

  // Only IDLE accepts; gating with RESET keeps req_ready low while held in reset.
  assign req_ready = RESET && (state == IDLE);

  // AD carries the address in T1 and write data in T2/T3/TW; otherwise released.
  assign AD = ad_oe ? ad_out : 8'hzz;

  // The timeout fires on the TW cycle in which the counter reaches MAX_WAIT.
  assign wait_expired = (MAX_WAIT != 0) && (wait_cnt == CW'(MAX_WAIT));

  // Bus-cycle sequencer; every pin is registered and set up for the state being entered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cur_write <= 1'b0;
      cur_wdata <= 8'h00;
      ad_out    <= 8'h00;
      ad_oe     <= 1'b0;
      ALE       <= 1'b0;
      RD_n      <= 1'b1;
      WR_n      <= 1'b1;
      DEN_n     <= 1'b1;
      DTR       <= 1'b1;
      IOM       <= 1'b0;
      A         <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= T1;
            cur_write <= req_write;
            cur_wdata <= req_wdata;
            ALE       <= 1'b1;
            A         <= req_addr[AW-1:8];
            IOM       <= req_io;
            DTR       <= req_write;
            ad_out    <= req_addr[7:0];
            ad_oe     <= 1'b1;
          end
        end
        T1: begin
          state  <= T2;
          ALE    <= 1'b0;
          RD_n   <= cur_write;
          WR_n   <= ~cur_write;
          DEN_n  <= 1'b0;
          ad_out <= cur_wdata;
          ad_oe  <= cur_write;
        end
        T2: begin
          state <= T3;
        end
        T3, TW: begin
          if (READY || ((state == TW) && wait_expired)) begin
            state     <= T4;
            RD_n      <= 1'b1;
            WR_n      <= 1'b1;
            DEN_n     <= 1'b1;
            ad_oe     <= 1'b0;
            rsp_valid <= 1'b1;
            if (READY) begin
              rsp_err <= 1'b0;
              if (!cur_write) begin
                rsp_rdata <= AD;
              end
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 8'h00;
            end
          end else begin
            state    <= TW;
            wait_cnt <= (state == T3) ? CW'(1) : wait_cnt + CW'(1);
          end
        end
        T4: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_8088.sv
// Directed bench for bus_master_8088 with a byte-wide responder model and a
// response scoreboard fed at request acceptance and drained on rsp_valid.
module tb_bus_master_8088;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        ALE;
  logic        RD_n;
  logic        WR_n;
  logic        IOM;
  logic        DEN_n;
  logic        DTR;
  logic [11:0] A;
  wire  [7:0]  AD;
  logic        READY = 1'b1;

  typedef struct {
    logic        write;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    int          lat;
    int          acc;
    logic        rsp;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          ale_cyc1 = 0;
  int          ale_cyc2 = 0;
  logic [7:0]  hold_rdata = 8'h00;

  logic [7:0]  mem [256];
  logic [19:0] lat_addr = 20'h0;
  int          strobe_cnt = 0;
  int          wait_cycles = 0;
  logic        park = 1'b0;
  bit          loaded = 1'b0;

  bus_master_8088 #(.MAX_WAIT(15), .AW(20)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_io    (req_io),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ALE       (ALE),
    .RD_n      (RD_n),
    .WR_n      (WR_n),
    .IOM       (IOM),
    .DEN_n     (DEN_n),
    .DTR       (DTR),
    .A         (A),
    .AD        (AD),
    .READY     (READY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Responder drives read data during RD_n; park puts a known value on an otherwise idle bus.
  assign AD = !RD_n ? mem[lat_addr[7:0]] : (park ? 8'h00 : 8'hzz);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: latch address on ALE, store write data, hold READY low for wait_cycles from T3.
  always @(negedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8'h45] = 8'hA5;
      mem[8'hB1] = 8'h5A;
      mem[8'h10] = 8'hEE;
      loaded = 1'b1;
    end
    if (ALE) lat_addr = {A, AD};
    if (!RD_n || !WR_n) strobe_cnt = strobe_cnt + 1;
    else strobe_cnt = 0;
    if (!WR_n) mem[lat_addr[7:0]] = AD;
    READY = !((!RD_n || !WR_n) && strobe_cnt >= 2 && strobe_cnt < 2 + wait_cycles);
  end

  // Monitor: bus invariants, T1 address phase, write data phase, and scoreboard drain.
  always @(negedge CLK) begin
    if (RESET) begin
      checkOutput("rd_wr_overlap", 32'(RD_n | WR_n), 32'd1);
      checkOutput("ale_during_strobe", 32'(ALE & (!RD_n | !WR_n)), 32'd0);
      if (ALE) begin
        ale_cyc2 = ale_cyc1;
        ale_cyc1 = cyc;
        checkOutput("ale_has_req", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          checkOutput("t1_a", 32'(A), 32'(sb[$].addr[19:8]));
          checkOutput("t1_ad", 32'(AD), 32'(sb[$].addr[7:0]));
          checkOutput("t1_iom", 32'(IOM), 32'(sb[$].io));
          checkOutput("t1_dtr", 32'(DTR), 32'(sb[$].write));
        end
      end
      if (!RD_n || !WR_n) checkOutput("den_active", 32'(DEN_n), 32'd0);
      if (!WR_n && sb.size() > 0) checkOutput("wr_data", 32'(AD), 32'(sb[$].wdata));
      if (rsp_valid) begin
        checkOutput("rsp_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          checkOutput("rsp_expected", 32'(sb[0].rsp), 32'd1);
          checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(sb[0].rdata));
          checkOutput("rsp_err", 32'(rsp_err), 32'(sb[0].err));
          checkOutput("rsp_latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
          checkOutput("t4_strobes", 32'({RD_n, WR_n, DEN_n}), 32'b111);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input bit wr, input bit io, input logic [19:0] addr,
                               input logic [7:0] wdata, input logic [7:0] rdata,
                               input bit err, input int lat, input bit rsp);
    exp_t e;
    int t = 0;
    @(negedge CLK);
    while (!req_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    e.write = wr;
    e.io    = io;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = wr ? hold_rdata : rdata;
    e.err   = err;
    e.lat   = lat;
    e.acc   = cyc + 1;
    e.rsp   = rsp;
    if (!wr && rsp) hold_rdata = rdata;
    sb.push_back(e);
    req_write = wr;
    req_io    = io;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_io    = ~io;
    req_addr  = 20'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_io    = 1'b0;
    req_addr  = 20'h0;
    req_wdata = 8'h0;
    park      = 1'b1;

    #23;
    checkOutput("rst_ale", 32'(ALE), 32'd0);
    checkOutput("rst_rd_n", 32'(RD_n), 32'd1);
    checkOutput("rst_wr_n", 32'(WR_n), 32'd1);
    checkOutput("rst_den_n", 32'(DEN_n), 32'd1);
    checkOutput("rst_dtr", 32'(DTR), 32'd1);
    checkOutput("rst_iom", 32'(IOM), 32'd0);
    checkOutput("rst_a", 32'(A), 32'd0);
    checkOutput("rst_ad_parked", 32'(AD), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);

    @(negedge CLK);
    RESET = 1'b1;
    park  = 1'b0;

    $display("[TB] memory read 0x12345");
    applyStimulus(1'b0, 1'b0, 20'h12345, 8'h00, 8'hA5, 1'b0, 4, 1'b1);
    wait_done();

    $display("[TB] IO write 0x00080 <- 0x3C");
    applyStimulus(1'b1, 1'b1, 20'h00080, 8'h3C, 8'h00, 1'b0, 4, 1'b1);
    wait_done();
    checkOutput("io_write_stored", 32'(mem[8'h80]), 32'h3C);

    $display("[TB] read with 3 wait states");
    wait_cycles = 3;
    applyStimulus(1'b0, 1'b0, 20'h00AB1, 8'h00, 8'h5A, 1'b0, 7, 1'b1);
    wait_done();

    $display("[TB] READY stuck low, timeout abort");
    wait_cycles = 1000;
    applyStimulus(1'b0, 1'b0, 20'h00010, 8'h00, 8'h00, 1'b1, 19, 1'b1);
    wait_done();
    wait_cycles = 0;

    $display("[TB] back-to-back write then read at 0xFFFFF");
    applyStimulus(1'b1, 1'b0, 20'hFFFFF, 8'h11, 8'h00, 1'b0, 4, 1'b1);
    applyStimulus(1'b0, 1'b0, 20'hFFFFF, 8'h00, 8'h11, 1'b0, 4, 1'b1);
    wait_done();
    checkOutput("b2b_ale_gap", 32'(ale_cyc1 - ale_cyc2), 32'd5);

    $display("[TB] reset during T3 of a write");
    applyStimulus(1'b1, 1'b0, 20'h00C33, 8'h77, 8'h00, 1'b0, 4, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    checkOutput("t3_wr_active", 32'(WR_n), 32'd0);
    #1;
    park  = 1'b1;
    RESET = 1'b0;
    #1;
    checkOutput("abort_wr_n", 32'(WR_n), 32'd1);
    checkOutput("abort_ale", 32'(ALE), 32'd0);
    checkOutput("abort_den_n", 32'(DEN_n), 32'd1);
    checkOutput("abort_ad_released", 32'(AD), 32'd0);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    sb.delete();
    hold_rdata = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    park  = 1'b0;
    @(negedge CLK);
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
    checkOutput("rdata_after_reset", 32'(rsp_rdata), 32'd0);

    $display("[TB] read after reset recovery");
    applyStimulus(1'b0, 1'b0, 20'h12345, 8'h00, 8'hA5, 1'b0, 4, 1'b1);
    wait_done();
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rdata_hold", 32'(rsp_rdata), 32'hA5);
    checkOutput("err_hold", 32'(rsp_err), 32'd0);
    checkOutput("rsp_valid_idle", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
